brick_map: RTL and testbench

//  Live brick-state store for the playfield. On request it copies one level's 7x12 brick

---
 rtl/brick_map_pkg.sv | 23 ++
 rtl/brick_map_if.sv | 32 +++
 rtl/brick_map.sv | 116 +++++++++++
 tb/tb_brick_map.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/brick_map_pkg.sv
// rtl/brick_map_pkg.sv - shared constants, state encoding and brick index helpers for brick_map
package brick_map_pkg;

    localparam int ROWS         = 7;
    localparam int COLS         = 12;
    localparam int BRICKS       = ROWS * COLS;
    localparam int LEVEL_STRIDE = 128;
    localparam int LEVEL_W      = 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    function automatic logic [6:0] brick_index(input logic [2:0] row, input logic [3:0] col);
        return 7'(int'(row) * COLS + int'(col));
    endfunction

    function automatic logic in_range(input logic [2:0] row, input logic [3:0] col);
        return (int'(row) < ROWS) && (int'(col) < COLS);
    endfunction

endpackage

// File: rtl/brick_map_if.sv
// rtl/brick_map_if.sv - load, ROM, query and clear signals of the brick map
interface brick_map_if;
    import brick_map_pkg::*;

    logic               load_req;
    logic [LEVEL_W-1:0] level;
    logic               load_busy;
    logic               load_done;
    logic [7:0]         rom_addr;
    logic               rom_data;
    logic [2:0]         query_row;
    logic [3:0]         query_col;
    logic               query_hit;
    logic               clear_req;
    logic [2:0]         clear_row;
    logic [3:0]         clear_col;
    logic               clear_ack;
    logic               clear_hit;
    logic [6:0]         bricks_left;
    logic               level_clear;

    modport master (
        output load_req, level, rom_data, query_row, query_col, clear_req, clear_row, clear_col,
        input  load_busy, load_done, rom_addr, query_hit, clear_ack, clear_hit, bricks_left, level_clear
    );

    modport slave (
        input  load_req, level, rom_data, query_row, query_col, clear_req, clear_row, clear_col,
        output load_busy, load_done, rom_addr, query_hit, clear_ack, clear_hit, bricks_left, level_clear
    );

endinterface

// File: rtl/brick_map.sv
// rtl/brick_map.sv - live brick-state store: level load from ROM, presence queries, brick clears
import brick_map_pkg::*;

module brick_map (
    input  logic        CLK,
    input  logic        RST_N,
    brick_map_if.slave  bus
);

    state_t            state, state_nx;
    logic [BRICKS-1:0] map_q;
    logic [6:0]        idx_q;
    logic [6:0]        pipe_idx_q;
    logic              pipe_valid_q;
    logic              issuing_q;
    logic [6:0]        count_q;
    logic              loaded_q;
    logic [7:0]        rom_addr_q;
    logic              load_done_q;
    logic              query_hit_q;
    logic              clear_ack_q;
    logic              clear_hit_q;

    logic       start;
    logic       last_write;
    logic       clear_ok;
    logic [6:0] q_idx;
    logic [6:0] c_idx;
    logic       c_present;

    assign start      = (state == IDLE) && bus.load_req;
    assign last_write = pipe_valid_q && (pipe_idx_q == 7'(BRICKS - 1));
    // A load request in the same cycle takes priority and the clear is dropped
    assign clear_ok   = (state == IDLE) && bus.clear_req && !bus.load_req;
    assign q_idx      = brick_index(bus.query_row, bus.query_col);
    assign c_idx      = brick_index(bus.clear_row, bus.clear_col);
    assign c_present  = in_range(bus.clear_row, bus.clear_col) && map_q[c_idx];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.load_req) state_nx = LOAD;
            LOAD: if (last_write)   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // ROM address for index k is issued after edge k; its data lands in the map two edges later
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            map_q        <= '0;
            idx_q        <= '0;
            pipe_idx_q   <= '0;
            pipe_valid_q <= 1'b0;
            issuing_q    <= 1'b0;
            count_q      <= '0;
            loaded_q     <= 1'b0;
            rom_addr_q   <= '0;
            load_done_q  <= 1'b0;
            query_hit_q  <= 1'b0;
            clear_ack_q  <= 1'b0;
            clear_hit_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            clear_ack_q <= clear_ok;
            clear_hit_q <= clear_ok && c_present;
            query_hit_q <= (state_nx == IDLE) && in_range(bus.query_row, bus.query_col) && map_q[q_idx];
            if (start) begin
                map_q        <= '0;
                count_q      <= '0;
                loaded_q     <= 1'b0;
                rom_addr_q   <= 8'(LEVEL_STRIDE * int'(bus.level));
                idx_q        <= '0;
                issuing_q    <= 1'b1;
                pipe_valid_q <= 1'b0;
            end else if (state == LOAD) begin
                pipe_valid_q <= issuing_q;
                pipe_idx_q   <= idx_q;
                if (issuing_q) begin
                    if (idx_q == 7'(BRICKS - 1)) begin
                        issuing_q <= 1'b0;
                    end else begin
                        idx_q      <= idx_q + 7'd1;
                        rom_addr_q <= rom_addr_q + 8'd1;
                    end
                end
                if (pipe_valid_q) begin
                    map_q[pipe_idx_q] <= bus.rom_data;
                    count_q           <= count_q + 7'(bus.rom_data);
                    if (last_write) begin
                        loaded_q    <= 1'b1;
                        load_done_q <= 1'b1;
                    end
                end
            end else if (clear_ok && c_present) begin
                map_q[c_idx] <= 1'b0;
                if (count_q != 7'd0) count_q <= count_q - 7'd1;
            end
        end
    end

    assign bus.load_busy   = (state == LOAD);
    assign bus.load_done   = load_done_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.query_hit   = query_hit_q;
    assign bus.clear_ack   = clear_ack_q;
    assign bus.clear_hit   = clear_hit_q;
    assign bus.bricks_left = count_q;
    assign bus.level_clear = loaded_q && (state != LOAD) && (count_q == 7'd0);

endmodule

// File: tb/tb_brick_map.sv
// tb/tb_brick_map.sv - self-checking bench for brick_map with level ROM model and scoreboard
module tb_brick_map;

    logic CLK;
    logic RST_N;
    brick_map_if bus ();

    brick_map dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    bit          rom [0:255];
    logic [11:0] l1_rows [0:6];
    logic [83:0] mmap;
    int          cnt;
    int          errors;
    int          checks;
    logic        clr_q [$];
    logic        qry_q [$];

    always @(posedge CLK) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input int r, input int c);
        if (r < 7 && c < 12) return mmap[r * 12 + c];
        return 1'b0;
    endfunction

    function automatic logic [20:0] outs();
        return {bus.load_busy, bus.load_done, bus.rom_addr, bus.query_hit, bus.clear_ack,
                bus.clear_hit, bus.bricks_left, bus.level_clear};
    endfunction

    task automatic step();
        logic e;
        @(negedge CLK);
        if (bus.clear_ack) begin
            if (clr_q.size() == 0) begin
                check("clr_unexpected", bus.clear_ack, 1'b0);
            end else begin
                e = clr_q.pop_front();
                check("clr_hit", bus.clear_hit, e);
                check("bricks_left", bus.bricks_left, cnt);
            end
        end else if (clr_q.size() != 0) begin
            e = clr_q.pop_front();
            check("clr_ack", bus.clear_ack, 1'b1);
        end
        if (qry_q.size() != 0) begin
            e = qry_q.pop_front();
            check("qry_hit", bus.query_hit, e);
        end
    endtask

    task automatic drive_clear(input int r, input int c);
        logic hit;
        bus.clear_req = 1'b1;
        bus.clear_row = 3'(r);
        bus.clear_col = 4'(c);
        hit = exp_bit(r, c);
        clr_q.push_back(hit);
        if (hit) begin
            mmap[r * 12 + c] = 1'b0;
            cnt--;
        end
    endtask

    task automatic clear_one(input int r, input int c);
        drive_clear(r, c);
        step();
        bus.clear_req = 1'b0;
    endtask

    task automatic query(input int r, input int c);
        bus.query_row = 3'(r);
        bus.query_col = 4'(c);
        qry_q.push_back(exp_bit(r, c));
        step();
    endtask

    // mode 0: plain load, 1: clear/query/second load during busy, 2: reset at load cycle 40
    task automatic do_load(input bit lvl, input int mode);
        int n, addr_bad, acks;
        bit done;
        logic [7:0] base, ea;
        base = lvl ? 8'd128 : 8'd0;
        @(negedge CLK);
        bus.load_req = 1'b1;
        bus.level    = lvl;
        if (mode == 1) begin
            bus.clear_req = 1'b1;
            bus.clear_row = 3'd0;
            bus.clear_col = 4'd0;
        end
        @(negedge CLK);
        n = 1;
        bus.load_req = 1'b0;
        check("busy_rise", bus.load_busy, 1'b1);
        addr_bad = 0;
        acks = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            ea = base + 8'((n - 1 > 83) ? 83 : n - 1);
            if (bus.load_busy && bus.rom_addr !== ea) addr_bad++;
            if (bus.clear_ack) acks++;
            if (mode == 1 && n == 10) begin
                bus.load_req  = 1'b1;
                bus.level     = !lvl;
                bus.query_row = 3'd0;
                bus.query_col = 4'd0;
            end
            if (mode == 1 && n == 11) begin
                bus.load_req  = 1'b0;
                bus.clear_req = 1'b0;
                check("busy_query", bus.query_hit, 1'b0);
            end
            if (mode == 2 && n == 40) begin
                RST_N = 1'b0;
                #1;
                check("rst_mid_load", outs(), 21'd0);
                @(negedge CLK);
                RST_N = 1'b1;
                mmap = '0;
                cnt  = 0;
                check("addr_before_rst", addr_bad, 0);
                return;
            end
            if (bus.load_done) done = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        check("load_done_seen", done, 1'b1);
        check("load_latency", n - 1, 85);
        check("rom_addr_seq", addr_bad, 0);
        check("load_no_ack", acks, 0);
        check("load_busy_fall", bus.load_busy, 1'b0);
        for (int i = 0; i < 84; i++) mmap[i] = rom[int'(base) + i];
        cnt = lvl ? 54 : 84;
        check("bricks_loaded", bus.bricks_left, cnt);
        @(negedge CLK);
        check("done_pulse", bus.load_done, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mmap   = '0;
        cnt    = 0;
        l1_rows[0] = 12'hFFF; l1_rows[1] = 12'h555; l1_rows[2] = 12'hFFF; l1_rows[3] = 12'h555;
        l1_rows[4] = 12'h0FF; l1_rows[5] = 12'h555; l1_rows[6] = 12'h807;
        for (int a = 0; a < 256; a++) rom[a] = 1'b0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 12; c++) begin
                rom[r * 12 + c]       = 1'b1;
                rom[128 + r * 12 + c] = l1_rows[r][c];
            end
        RST_N = 1'b0;
        bus.load_req = 1'b0; bus.level = 1'b0;
        bus.query_row = 3'd0; bus.query_col = 4'd0;
        bus.clear_req = 1'b0; bus.clear_row = 3'd0; bus.clear_col = 4'd0;
        #2;
        check("reset_state", outs(), 21'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        do_load(1'b0, 0);
        do_load(1'b1, 1);
        query(0, 5); query(1, 0); query(1, 1); query(6, 11); query(7, 0); query(0, 12);

        clear_one(1, 0);
        check("count_53", bus.bricks_left, 7'd53);
        clear_one(1, 0);
        clear_one(1, 1);
        clear_one(7, 3);
        check("level_clear_low", bus.level_clear, 1'b0);

        bus.query_row = 3'd1;
        bus.query_col = 4'd2;
        qry_q.push_back(exp_bit(1, 2));
        drive_clear(1, 2);
        step();
        bus.clear_req = 1'b0;

        do_load(1'b0, 2);
        do_load(1'b1, 0);
        query(1, 1); query(3, 1); query(4, 9); query(2, 7);

        do_load(1'b0, 0);
        for (int i = 0; i < 84; i++) begin
            drive_clear(i / 12, i % 12);
            step();
            if (i == 82) check("level_clear_83", bus.level_clear, 1'b0);
            if (i == 83) check("level_clear_84", bus.level_clear, 1'b1);
        end
        bus.clear_req = 1'b0;
        clear_one(0, 0);
        check("count_zero", bus.bricks_left, 7'd0);
        check("level_clear_hold", bus.level_clear, 1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
